// File: rtl/pulse_peak_finder.sv
`default_nettype none
// pulse_peak_finder: threshold pulse detector emitting {peak amplitude, peak time, width} records
// over valid/ready. Define PEAK_BASELINE_EN to subtract a 16-sample running-average baseline.
module pulse_peak_finder #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int MIN_WIDTH = 2,
  parameter int DEAD_TIME = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     peak_valid,
  input  logic                     peak_ready,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic [TS_W-1:0]          peak_time,
  output logic [7:0]               peak_width,
  output logic [7:0]               drop_cnt
);
  localparam int DC_W = (DEAD_TIME < 2) ? 1 : $clog2(DEAD_TIME + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] s_q, max_q, baseline;
  logic [TS_W-1:0]          ts_cnt_q, ts_q, tmax_q;
  logic [7:0]               width_q;
  logic [DC_W-1:0]          dcnt_q;
  logic signed [DATA_W:0]   diff, thr_ext, amp_full;
  logic signed [DATA_W-1:0] amp_sat;
  logic                     above, width_ok, start, track, emit;

  logic                     valid_q;
  logic signed [DATA_W-1:0] amp_q;
  logic [TS_W-1:0]          time_q;
  logic [7:0]               wout_q, drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q      <= '0;
      ts_q     <= '0;
      ts_cnt_q <= '0;
    end else begin
      s_q      <= in_data;
      ts_q     <= ts_cnt_q;
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
    end
  end

`ifdef PEAK_BASELINE_EN
  logic signed [DATA_W-1:0] hist_q [16];
  logic signed [DATA_W+3:0] sum_q;

  // The sample that trips the threshold belongs to the pulse, so it is kept out of the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      for (int i = 0; i < 16; i++) hist_q[i] <= '0;
    end else if (state_q == ST_IDLE && !above) begin
      sum_q     <= sum_q + {{4{s_q[DATA_W-1]}}, s_q} - {{4{hist_q[15][DATA_W-1]}}, hist_q[15]};
      hist_q[0] <= s_q;
      for (int i = 1; i < 16; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign baseline = sum_q[DATA_W+3:4];
`else
  assign baseline = '0;
`endif

  assign diff     = {s_q[DATA_W-1], s_q} - {baseline[DATA_W-1], baseline};
  assign thr_ext  = {threshold[DATA_W-1], threshold};
  assign above    = diff > thr_ext;
  assign width_ok = 32'(width_q) >= MIN_WIDTH;
  assign amp_full = {max_q[DATA_W-1], max_q} - {baseline[DATA_W-1], baseline};

  always_comb begin
    amp_sat = amp_full[DATA_W-1:0];
    if (amp_full[DATA_W] != amp_full[DATA_W-1])
      amp_sat = amp_full[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (above) state_d = ST_PULSE;
      ST_PULSE: if (!above) state_d = (width_ok && DEAD_TIME != 0) ? ST_DEAD : ST_IDLE;
      ST_DEAD:  if (dcnt_q == DC_W'(1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start = (state_q == ST_IDLE)  && above;
    track = (state_q == ST_PULSE) && above;
    emit  = (state_q == ST_PULSE) && !above && width_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q   <= '0;
      tmax_q  <= '0;
      width_q <= '0;
      dcnt_q  <= '0;
    end else begin
      if (start) begin
        max_q   <= s_q;
        tmax_q  <= ts_q;
        width_q <= 8'd1;
      end else if (track) begin
        if (width_q != 8'hFF) width_q <= width_q + 8'd1;
        if (s_q > max_q) begin
          max_q  <= s_q;
          tmax_q <= ts_q;
        end
      end
      if (emit)                   dcnt_q <= DC_W'(DEAD_TIME);
      else if (state_q == ST_DEAD) dcnt_q <= dcnt_q - DC_W'(1);
    end
  end

  // A held record wins over a new one unless it is being handed off this very cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      amp_q   <= '0;
      time_q  <= '0;
      wout_q  <= '0;
      drop_q  <= '0;
    end else if (emit && valid_q && !peak_ready) begin
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (emit) begin
      valid_q <= 1'b1;
      amp_q   <= amp_sat;
      time_q  <= tmax_q;
      wout_q  <= width_q;
    end else if (valid_q && peak_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign peak_valid = valid_q;
  assign peak_amp   = amp_q;
  assign peak_time  = time_q;
  assign peak_width = wout_q;
  assign drop_cnt   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_peak_finder.sv
`default_nettype none
// Bench for pulse_peak_finder: a vector table of pulse shapes plus hand-written sequences
// for dead time, back-pressure, baseline and reset; records are matched against a queue.
module tb_pulse_peak_finder;
  localparam int DW = 16;
  localparam int TW = 32;
`ifdef PEAK_BASELINE_EN
  localparam int BL_AMP = 160;
`else
  localparam int BL_AMP = 200;
`endif

  logic                 clk        = 1'b0;
  logic                 reset      = 1'b1;
  logic signed [DW-1:0] in_data    = '0;
  logic signed [DW-1:0] threshold  = 16'sd100;
  logic                 peak_ready = 1'b1;
  logic                 peak_valid;
  logic signed [DW-1:0] peak_amp;
  logic [TW-1:0]        peak_time;
  logic [7:0]           peak_width, drop_cnt;

  logic                 nd_ready = 1'b1;
  logic                 nd_valid;
  logic signed [DW-1:0] nd_amp;
  logic [TW-1:0]        nd_time;
  logic [7:0]           nd_width, nd_drop;

  typedef struct {
    logic signed [DW-1:0] amp;
    logic [TW-1:0]        tm;
    logic [7:0]           width;
  } rec_t;

  typedef struct {
    int                       n;
    int                       thr;
    logic signed [5:0][DW-1:0] s;
    bit                       has;
    int                       pk;
    int                       amp;
    int                       width;
  } vec_t;

  rec_t          exp_q[$];
  vec_t          vecs[9];
  int            tests = 0;
  int            fails = 0;
  int            main_xfers = 0;
  int            nd_xfers = 0;
  int            thr_pipe = 100;
  logic [TW-1:0] ts_model = '0;

  always #5 clk = ~clk;

  pulse_peak_finder #(.DATA_W(DW), .TS_W(TW), .MIN_WIDTH(2), .DEAD_TIME(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .threshold(threshold),
    .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_amp(peak_amp),
    .peak_time(peak_time), .peak_width(peak_width), .drop_cnt(drop_cnt)
  );

  pulse_peak_finder #(.DATA_W(DW), .TS_W(TW), .MIN_WIDTH(2), .DEAD_TIME(0)) dut_nd (
    .clk(clk), .reset(reset), .in_data(in_data), .threshold(threshold),
    .peak_valid(nd_valid), .peak_ready(nd_ready), .peak_amp(nd_amp),
    .peak_time(nd_time), .peak_width(nd_width), .drop_cnt(nd_drop)
  );

  // Free-running timestamp as defined for the block: cleared by reset, +1 per clock.
  always @(posedge clk) ts_model <= reset ? '0 : ts_model + 32'd1;

  always @(posedge clk) if (!reset && nd_valid && nd_ready) nd_xfers <= nd_xfers + 1;

  always @(negedge clk) begin
    rec_t e;
    if (!reset && peak_valid && peak_ready) begin
      tests++;
      main_xfers++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL record: unexpected record amp=%0d time=%0d width=%0d",
                 peak_amp, peak_time, peak_width);
      end else begin
        e = exp_q.pop_front();
        if (e.amp !== peak_amp || e.tm !== peak_time || e.width !== peak_width) begin
          fails++;
          $display("FAIL record: got amp=%0d time=%0d width=%0d, expected amp=%0d time=%0d width=%0d",
                   peak_amp, peak_time, peak_width, e.amp, e.tm, e.width);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Threshold is delayed one sample so it lines up with the registered sample it is compared to.
  task automatic drive(input int smp, input int thr);
    @(posedge clk);
    #1;
    in_data   = smp[DW-1:0];
    threshold = thr_pipe[DW-1:0];
    thr_pipe  = thr;
  endtask

  task automatic push(input int amp, input int width);
    rec_t r;
    r.amp   = amp[DW-1:0];
    r.tm    = ts_model;
    r.width = width[7:0];
    exp_q.push_back(r);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) drive(0, 100);
  endtask

  function automatic vec_t mk(input int n, input int thr, input int a, input int b, input int c,
                              input int d, input int e, input int f, input bit has,
                              input int pk, input int amp, input int width);
    vec_t v;
    v.n = n;  v.thr = thr;
    v.s[0] = a[DW-1:0]; v.s[1] = b[DW-1:0]; v.s[2] = c[DW-1:0];
    v.s[3] = d[DW-1:0]; v.s[4] = e[DW-1:0]; v.s[5] = f[DW-1:0];
    v.has = has; v.pk = pk; v.amp = amp; v.width = width;
    return v;
  endfunction

  initial begin
    int base_main;
    int base_nd;

    vecs[0] = mk(6, 100, 0, 0, 150, 300, 250, 50,       1, 3, 300, 3);
    vecs[1] = mk(2, 100, 500, 0, 0, 0, 0, 0,            0, 0, 0, 0);
    vecs[2] = mk(4, 100, 200, 200, 200, 0, 0, 0,        1, 0, 200, 3);
    vecs[3] = mk(3, 100, 101, 101, 0, 0, 0, 0,          1, 0, 101, 2);
    vecs[4] = mk(3, 100, 100, 100, 100, 0, 0, 0,        0, 0, 0, 0);
    vecs[5] = mk(3, 100, 120, 130, -50, 0, 0, 0,        1, 1, 130, 2);
    vecs[6] = mk(5, 100, 150, 400, 400, 300, 0, 0,      1, 1, 400, 4);
    vecs[7] = mk(3, -10, -5, -3, -20, 0, 0, 0,          1, 1, -3, 2);
    vecs[8] = mk(3, 100, 32767, 32767, -32768, 0, 0, 0, 1, 0, 32767, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset peak_valid", peak_valid, 0);
    check("reset peak_amp",   peak_amp, 0);
    check("reset peak_time",  peak_time, 0);
    check("reset peak_width", peak_width, 0);
    check("reset drop_cnt",   drop_cnt, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      zeros(24);
      for (int i = 0; i < vecs[v].n; i++) begin
        drive(int'($signed(vecs[v].s[i])), vecs[v].thr);
        if (vecs[v].has && i == vecs[v].pk) push(vecs[v].amp, vecs[v].width);
      end
      @(negedge clk);
      @(negedge clk);
      check($sformatf("vec%0d valid one edge after fall", v), peak_valid, 0);
      @(negedge clk);
      check($sformatf("vec%0d valid two edges after fall", v), peak_valid, vecs[v].has);
    end
    check("drop_cnt after table", drop_cnt, 0);

    // Second pulse lands inside the dead window of the main DUT but not of the zero-dead-time one.
    zeros(24);
    base_main = main_xfers;
    base_nd   = nd_xfers;
    drive(200, 100); push(200, 2);
    drive(200, 100);
    zeros(3);
    drive(200, 100);
    drive(200, 100);
    zeros(20);
    check("dead time records (DEAD_TIME=8)", main_xfers - base_main, 1);
    check("dead time records (DEAD_TIME=0)", nd_xfers - base_nd, 2);

    // Back-pressure: hold, drop, then replace on a coincident transfer.
    zeros(24);
    peak_ready = 1'b0;
    drive(300, 100); push(300, 2);
    drive(300, 100);
    zeros(12);
    check("held valid", peak_valid, 1);
    drive(250, 100);
    drive(250, 100);
    drive(250, 100);
    zeros(4);
    check("drop_cnt after drop", drop_cnt, 1);
    check("held amp after drop", peak_amp, 300);
    check("held width after drop", peak_width, 2);
    check("held valid after drop", peak_valid, 1);
    zeros(12);
    drive(400, 100); push(400, 2);
    drive(400, 100);
    drive(0, 100);
    drive(0, 100);
    peak_ready = 1'b1;
    drive(0, 100);
    peak_ready = 1'b0;
    @(negedge clk);
    check("replace valid stays", peak_valid, 1);
    check("replace amp", peak_amp, 400);
    check("replace drop_cnt", drop_cnt, 1);
    peak_ready = 1'b1;
    zeros(4);

    // Baseline: settled level of 40, then a pulse and a sub-threshold excursion.
    zeros(24);
    for (int i = 0; i < 20; i++) drive(40, 100);
    drive(160, 100);
    drive(200, 100); push(BL_AMP, 2);
    drive(40, 100);
    for (int i = 0; i < 12; i++) drive(40, 100);
    drive(130, 100);
    for (int i = 0; i < 8; i++) drive(40, 100);
    check("no record from 130 sample", peak_valid, 0);
    zeros(24);

    // Reset in the middle of a pulse.
    drive(300, 100);
    drive(300, 100);
    drive(300, 100);
    @(posedge clk);
    #1 reset = 1'b1;
    in_data = '0;
    @(posedge clk);
    #1;
    check("midreset peak_valid", peak_valid, 0);
    check("midreset peak_amp",   peak_amp, 0);
    check("midreset peak_time",  peak_time, 0);
    check("midreset peak_width", peak_width, 0);
    check("midreset drop_cnt",   drop_cnt, 0);
    reset = 1'b0;
    zeros(20);
    check("no record after reset", peak_valid, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("expected records all seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
